// File: rtl/mcu_spi_slave.sv
// Oversampled SPI mode-0 slave running entirely on clk32: byte deserializer with strobe and reply serializer.
// Define MCU_SPI_TIMEOUT_EN to abort partial bytes after TIMEOUT_CYCLES idle clk32 cycles.
module mcu_spi_slave #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk32,
  input  logic       reset_n,
  input  logic       mcu_sclk,
  input  logic       mcu_csn,
  input  logic       mcu_mosi,
  output logic       mcu_miso,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic       busy,
  output logic       abort
);

  localparam logic [1:0] WAIT_IDLE = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] SHIFT     = 2'd2;

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("mcu_spi_slave: SYNC_STAGES and TIMEOUT_CYCLES must both be at least 2");
  end

  logic [SYNC_STAGES-1:0] sclk_sync_reg, csn_sync_reg, mosi_sync_reg;
  logic [SYNC_STAGES:0]   warm_reg;
  logic                   sclk_d_reg, csn_d_reg;
  logic [1:0]             state_reg;
  logic [2:0]             bit_cnt_reg;
  logic [6:0]             rx_shift_reg, tx_shift_reg;
  logic                   first_reg, strobe_pend_reg, first_pend_reg;
  logic                   sclk_s, csn_s, mosi_s;
  logic                   sclk_rise, sclk_fall, csn_fall;

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign csn_s     = csn_sync_reg[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign sclk_fall = ~sclk_s & sclk_d_reg;
  assign csn_fall  = ~csn_s & csn_d_reg;

  always_ff @(posedge clk32) begin
    if (!reset_n) begin
      sclk_sync_reg <= '0;
      csn_sync_reg  <= '1;
      mosi_sync_reg <= '1;
      sclk_d_reg    <= 1'b0;
      csn_d_reg     <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], mcu_sclk};
      csn_sync_reg  <= {csn_sync_reg[SYNC_STAGES-2:0], mcu_csn};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mcu_mosi};
      sclk_d_reg    <= sclk_s;
      csn_d_reg     <= csn_s;
    end
  end

`ifdef MCU_SPI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] timer_reg;
  logic          abort_reg;
  logic          timeout_hit;

  assign timeout_hit = (state_reg == SHIFT) && !csn_s && !sclk_rise && !sclk_fall &&
                       (timer_reg == TO_LIMIT) && (bit_cnt_reg != 3'd0);
  assign abort = abort_reg;

  // Saturates at the limit so an idle line on a byte boundary never re-triggers.
  always_ff @(posedge clk32) begin
    if (!reset_n || state_reg != SHIFT || sclk_rise || sclk_fall || timeout_hit) begin
      timer_reg <= '0;
    end else if (timer_reg != TO_LIMIT) begin
      timer_reg <= timer_reg + 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk32) begin
    if (!reset_n) begin
      state_reg       <= WAIT_IDLE;
      warm_reg        <= '0;
      bit_cnt_reg     <= 3'd0;
      rx_shift_reg    <= 7'd0;
      tx_shift_reg    <= 7'd0;
      first_reg       <= 1'b0;
      strobe_pend_reg <= 1'b0;
      first_pend_reg  <= 1'b0;
      mcu_miso        <= 1'b0;
      rx_data         <= 8'h00;
      rx_strobe       <= 1'b0;
      rx_first        <= 1'b0;
      tx_ack          <= 1'b0;
      busy            <= 1'b0;
`ifdef MCU_SPI_TIMEOUT_EN
      abort_reg       <= 1'b0;
`endif
    end else begin
      warm_reg        <= {warm_reg[SYNC_STAGES-1:0], 1'b1};
      rx_strobe       <= strobe_pend_reg;
      rx_first        <= strobe_pend_reg & first_pend_reg;
      strobe_pend_reg <= 1'b0;
      tx_ack          <= 1'b0;
`ifdef MCU_SPI_TIMEOUT_EN
      abort_reg       <= 1'b0;
`endif
      case (state_reg)
        // Synchronizers preload csn=1, so wait until they carry the real pin level.
        WAIT_IDLE: if (warm_reg[SYNC_STAGES] && csn_s) state_reg <= IDLE;
        IDLE: begin
          if (csn_fall) begin
            state_reg    <= SHIFT;
            tx_shift_reg <= tx_data[6:0];
            mcu_miso     <= tx_data[7];
            tx_ack       <= 1'b1;
            first_reg    <= 1'b1;
            bit_cnt_reg  <= 3'd0;
            rx_shift_reg <= 7'd0;
            busy         <= 1'b1;
          end
        end
        SHIFT: begin
          if (csn_s) begin
            state_reg    <= IDLE;
            busy         <= 1'b0;
            mcu_miso     <= 1'b0;
            rx_shift_reg <= 7'd0;
            bit_cnt_reg  <= 3'd0;
          end else if (sclk_rise) begin
            rx_shift_reg <= {rx_shift_reg[5:0], mosi_s};
            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              rx_data         <= {rx_shift_reg, mosi_s};
              strobe_pend_reg <= 1'b1;
              first_pend_reg  <= first_reg;
              first_reg       <= 1'b0;
            end
          end else if (sclk_fall) begin
            if (bit_cnt_reg != 3'd0) begin
              tx_shift_reg <= {tx_shift_reg[5:0], 1'b0};
              mcu_miso     <= tx_shift_reg[6];
            end else begin
              tx_shift_reg <= tx_data[6:0];
              mcu_miso     <= tx_data[7];
              tx_ack       <= 1'b1;
            end
          end
`ifdef MCU_SPI_TIMEOUT_EN
          else if (timeout_hit) begin
            rx_shift_reg <= 7'd0;
            bit_cnt_reg  <= 3'd0;
            abort_reg    <= 1'b1;
            tx_shift_reg <= tx_data[6:0];
            mcu_miso     <= tx_data[7];
            tx_ack       <= 1'b1;
          end
`endif
        end
        default: state_reg <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_spi_slave.sv
// Randomized SPI-master bench for mcu_spi_slave with a frame-level reference model.
module tb_mcu_spi_slave;
  localparam int SS = 2;
  localparam int TO = 64;

  logic       clk32 = 1'b0;
  logic       reset_n = 1'b0;
  logic       mcu_sclk = 1'b0;
  logic       mcu_csn = 1'b1;
  logic       mcu_mosi = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       mcu_miso, rx_strobe, rx_first, tx_ack, busy, abort;
  logic [7:0] rx_data;

  mcu_spi_slave #(.SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
    .clk32(clk32), .reset_n(reset_n), .mcu_sclk(mcu_sclk), .mcu_csn(mcu_csn),
    .mcu_mosi(mcu_mosi), .mcu_miso(mcu_miso), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .rx_first(rx_first), .tx_data(tx_data), .tx_ack(tx_ack), .busy(busy), .abort(abort)
  );

  always #10 clk32 = ~clk32;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int n_abort = 0;
  logic [8:0] got_rx[$];
  logic [7:0] tx_sent[$];
  logic [7:0] tx_plan[$];
  logic [7:0] frame_mosi[$];

  always @(posedge clk32) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: records received bytes and sampled reply bytes, feeds the next reply byte.
  initial begin
    logic prev_strobe, prev_ack;
    prev_strobe = 1'b0;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk32);
      if (rx_strobe === 1'b1) begin
        got_rx.push_back({rx_first, rx_data});
        check("strobe_pulse", prev_strobe, 1'b0);
        check("strobe_latency", cyc - last_rise_cyc, SS + 2);
      end
      if (tx_ack === 1'b1) begin
        tx_sent.push_back(tx_data);
        check("ack_pulse", prev_ack, 1'b0);
        if (tx_plan.size() > 0) tx_data = tx_plan.pop_front();
        else tx_data = 8'($urandom);
      end
      if (abort === 1'b1) n_abort++;
      prev_strobe = rx_strobe;
      prev_ack = tx_ack;
    end
  end

  task automatic clock_bit(input logic v, input int h, input logic exp_busy,
                           input bit raise_csn, output logic m);
    mcu_mosi = v;
    repeat (h) @(negedge clk32);
    m = mcu_miso;
    check("busy_in_frame", busy, exp_busy);
    mcu_sclk = 1'b1;
    last_rise_cyc = cyc;
    if (raise_csn) mcu_csn = 1'b1;
    repeat (h) @(negedge clk32);
    mcu_sclk = 1'b0;
  endtask

  // Drives one frame of nbits from frame_mosi and checks it against the frame-level model.
  task automatic spi_frame(input int nbits, input int h, input bit collide, input bit live);
    logic miso_q[$];
    logic m;
    logic [7:0] b;
    int full;
    got_rx.delete();
    tx_sent.delete();
    n_abort = 0;
    @(negedge clk32);
    mcu_csn = 1'b0;
    repeat (h) @(negedge clk32);
    for (int i = 0; i < nbits; i++) begin
      b = frame_mosi[i / 8];
      clock_bit(b[7 - (i % 8)], h, live, collide && (i == nbits - 1), m);
      miso_q.push_back(m);
    end
    if (!collide) begin
      repeat (h) @(negedge clk32);
      mcu_csn = 1'b1;
    end
    repeat (4 * h) @(negedge clk32);
    full = collide ? (nbits - 1) / 8 : nbits / 8;
    check("rx_count", got_rx.size(), live ? full : 0);
    for (int k = 0; k < got_rx.size() && k < full; k++)
      check("rx_byte", got_rx[k], {k == 0, frame_mosi[k]});
    check("ack_count", tx_sent.size(), live ? full + 1 : 0);
    if (live && tx_sent.size() == full + 1) begin
      for (int i = 0; i < nbits; i++) begin
        b = tx_sent[i / 8];
        check("miso_bit", miso_q[i], b[7 - (i % 8)]);
      end
    end
    check("busy_after", busy, 1'b0);
    check("abort_none", n_abort, 0);
    $display("frame bits=%0d h=%0d collide=%0d live=%0d rx=%0d acks=%0d",
             nbits, h, collide, live, got_rx.size(), tx_sent.size());
  endtask

  initial begin
    logic m;
    tx_data = 8'($urandom);
    repeat (4) @(negedge clk32);
    check("rst_miso", mcu_miso, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_strobe", rx_strobe, 1'b0);
    check("rst_first", rx_first, 1'b0);
    check("rst_ack", tx_ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_abort", abort, 1'b0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk32);

    frame_mosi = '{8'hA5};
    spi_frame(8, 8, 1'b0, 1'b1);

    tx_data = 8'h3C;
    tx_plan = '{8'h81};
    frame_mosi = '{8'h12, 8'h34};
    spi_frame(16, 8, 1'b0, 1'b1);

    frame_mosi = '{8'hC3};
    spi_frame(5, 9, 1'b0, 1'b1);
    frame_mosi = '{8'hFF};
    spi_frame(8, 8, 1'b0, 1'b1);

    // Reset while the master holds csn low: the slave must not join the frame.
    frame_mosi = '{8'h5A, 8'h6B, 8'h7C};
    @(negedge clk32);
    mcu_csn = 1'b0;
    repeat (8) @(negedge clk32);
    for (int i = 0; i < 3; i++) clock_bit(1'(i), 8, 1'b1, 1'b0, m);
    reset_n = 1'b0;
    repeat (4) @(negedge clk32);
    reset_n = 1'b1;
    spi_frame(24, 8, 1'b0, 1'b0);
    frame_mosi = '{8'h96};
    spi_frame(8, 8, 1'b0, 1'b1);

    frame_mosi = '{8'hE7};
    spi_frame(8, 8, 1'b1, 1'b1);
    frame_mosi = '{8'h11, 8'h22};
    spi_frame(16, 10, 1'b1, 1'b1);

    for (int f = 0; f < 12; f++) begin
      frame_mosi.delete();
      for (int k = 0; k < 3; k++) frame_mosi.push_back(8'($urandom));
      spi_frame(int'($urandom_range(1, 24)), int'($urandom_range(8, 12)),
                ($urandom_range(0, 4) == 0), 1'b1);
    end

`ifdef MCU_SPI_TIMEOUT_EN
    got_rx.delete();
    tx_sent.delete();
    n_abort = 0;
    @(negedge clk32);
    mcu_csn = 1'b0;
    repeat (8) @(negedge clk32);
    for (int i = 0; i < 3; i++) clock_bit(1'(i), 8, 1'b1, 1'b0, m);
    repeat (70) @(negedge clk32);
    check("abort_count", n_abort, 1);
    frame_mosi = '{8'h5A};
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = frame_mosi[0];
      clock_bit(b[7 - i], 8, 1'b1, 1'b0, m);
    end
    repeat (8) @(negedge clk32);
    mcu_csn = 1'b1;
    repeat (32) @(negedge clk32);
    check("to_rx_count", got_rx.size(), 1);
    if (got_rx.size() > 0) check("to_rx_byte", got_rx[0], {1'b1, 8'h5A});
    check("to_ack_count", tx_sent.size(), 3);
    check("to_abort_total", n_abort, 1);
    $display("timeout frame rx=%0d acks=%0d aborts=%0d", got_rx.size(), tx_sent.size(), n_abort);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mcu_spi_slave.md
Name: mcu_spi_slave

Overview:
- Oversampled SPI slave that consumes the selected MCU SPI signals (sclk, csn, mosi) after the internal-BL616 / external-M0S mux, and produces the MISO line back to the MCU.
- Everything runs in the clk32 domain, with no SPI-clocked logic.
- Deserializes MOSI into bytes with a one-cycle strobe, and serializes host-supplied reply bytes onto MISO.
- Sits directly between the top-level MCU mux and the MCU command decoder inside the core.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on each of sclk/csn/mosi (minimum 2).
- TIMEOUT_CYCLES, 4096, idle clk32 cycles with csn low and no sclk edge before a partial byte is aborted (only used with the optional feature).

Ports:
- clk32  in  1  system clock, 32 MHz.
- reset_n  in  1  reset; synchronous, active-low.
- mcu_sclk  in  1  SPI clock from MCU mux; asynchronous.
- mcu_csn  in  1  SPI chip select, active-low; asynchronous.
- mcu_mosi  in  1  data from MCU; asynchronous.
- mcu_miso  out  1  data to MCU.
- rx_data  out  8  last received byte, MSB first on the wire.
- rx_strobe  out  1  one-cycle pulse, rx_data valid.
- rx_first  out  1  high with rx_strobe on the first byte after csn falls.
- tx_data  in  8  next reply byte; must be stable when tx_ack pulses.
- tx_ack  out  1  one-cycle pulse, tx_data sampled into the shifter.
- busy  out  1  synchronized csn low and frame accepted.
- abort  out  1  one-cycle pulse, partial byte discarded (optional feature only; tied 0 otherwise).

Behaviour:
- **SPI mode 0.** MOSI is sampled on sclk rising edge and MISO is updated on sclk falling edge. Edges are detected by comparing the last synchronizer stage with a one-cycle delayed copy.
- **Reset (reset_n=0 at a clk32 edge).** Outputs become: mcu_miso=0, rx_data=0x00, rx_strobe=0, rx_first=0, tx_ack=0, busy=0, abort=0. Bit counter is 0, state is WAIT_IDLE, and synchronizers are loaded with 1 (sclk with 0).
- **FSM states:**
  - WAIT_IDLE: ignore everything until synced csn=1, then go to IDLE. This prevents mid-frame alignment after reset.
  - IDLE: on synced csn falling edge, go to SHIFT. In that transition cycle: load tx_data into the tx shifter, mcu_miso=tx_data[7], pulse tx_ack, set first flag, bit counter=0, busy=1.
  - SHIFT, sclk rising edge: rx shifter becomes {rx_shift[6:0], mosi_sync}, bit counter +1 (3-bit, wraps 7→0).
    - When the counter wraps, register rx_data, pulse rx_strobe the next cycle, rx_first=first flag, then clear the first flag.
  - SHIFT, sclk falling edge:
    - Counter≠0: shift tx left and drive the next bit.
    - Counter==0 (byte boundary): reload tx_data, pulse tx_ack, drive tx_data[7].
  - SHIFT, synced csn=1: go to IDLE, busy=0, mcu_miso=0, discard partial rx bits, counter=0.
- **Latency.** rx_strobe goes high SYNC_STAGES+2 clk32 cycles after the 8th sclk rising edge at the pin. mcu_miso changes SYNC_STAGES+1 cycles after the falling edge at the pin.
  - Maximum supported sclk is therefore clk32/(2*(SYNC_STAGES+2)), i.e. 4 MHz at default.
- **Simultaneous events.** If a csn rising edge and an sclk edge are detected in the same cycle, csn wins: no strobe, no tx_ack.
- **Strobe timing.** rx_strobe and tx_ack are never high for more than one cycle. Back-to-back bytes produce strobes at least 8 sclk periods apart.
- **Underflow.** tx_data is not checked; whatever value is present when tx_ack pulses is sent.

Optional Feature:
- **MCU_SPI_TIMEOUT_EN defined:**
  - In SHIFT, a counter of width clog2(TIMEOUT_CYCLES)+1 increments each clk32 cycle with no sclk edge, and clears on any edge.
  - On reaching TIMEOUT_CYCLES with counter≠0, the partial byte is discarded, bit counter=0, abort pulses for one cycle, and the tx shifter reloads with a tx_ack pulse.
  - Stays in SHIFT.
- **MCU_SPI_TIMEOUT_EN undefined:** no timer exists, abort is tied to 0, and partial bytes persist until csn rises.

Test Plan:
- Reset then frame: hold reset_n=0 4 cycles, csn low, send 0xA5 at sclk=2 MHz → single rx_strobe with rx_data=0xA5, rx_first=1, busy=1 throughout.
- Full duplex: tx_data=0x3C at csn fall, then 0x81. MCU sends 0x12,0x34 → MISO bytes 0x3C,0x81; rx 0x12 (rx_first=1) then 0x34 (rx_first=0); tx_ack exactly 2 times before the final byte's falling edges.
- Mid-byte csn release: send 5 bits, raise csn, then new frame with 0xFF → no strobe for the partial byte; next strobe rx_data=0xFF, rx_first=1.
- Reset asserted mid-frame with csn still low, then 3 more bytes clocked → no rx_strobe until csn goes high and low again.
- Edge collision: 8th sclk rising edge and csn rise arrive on the same synced cycle → no rx_strobe, busy=0.
- MCU_SPI_TIMEOUT_EN, TIMEOUT_CYCLES=64: 3 bits then sclk idle 70 cycles, csn low → abort pulse once at cycle 64; following 8 bits 0x5A → rx_data=0x5A.
